// File: rtl/main_fsm.sv
// Multicycle RV32I main control FSM: state sequencing, per-state datapath
// controls, PC write enable, immediate-format select and ALU operation decode.
module main_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic [3:0] state
);

  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] MEMADR   = 4'd2;
  localparam logic [3:0] MEMREAD  = 4'd3;
  localparam logic [3:0] MEMWB    = 4'd4;
  localparam logic [3:0] MEMWRITE = 4'd5;
  localparam logic [3:0] EXECUTER = 4'd6;
  localparam logic [3:0] EXECUTEI = 4'd7;
  localparam logic [3:0] ALUWB    = 4'd8;
  localparam logic [3:0] BEQ      = 4'd9;
  localparam logic [3:0] JAL      = 4'd10;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  logic [3:0] next_state;
  logic [1:0] alu_op;
  logic       pc_update;
  logic       branch;
  logic       mem_write_raw;
  logic       ir_write_raw;
  logic       reg_write_raw;

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= next_state;
  end

  always_comb begin
    next_state = FETCH;
    case (state)
      FETCH:    next_state = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_R:         next_state = EXECUTER;
          OP_I:         next_state = EXECUTEI;
          OP_BEQ:       next_state = BEQ;
          OP_JAL:       next_state = JAL;
          default:      next_state = FETCH;
        endcase
      end
      MEMADR:   next_state = (op == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:  next_state = MEMWB;
      EXECUTER, EXECUTEI, JAL: next_state = ALUWB;
      default:  next_state = FETCH;
    endcase
  end

  always_comb begin
    AdrSrc        = 1'b0;
    ResultSrc     = 2'b00;
    ALUSrcA       = 2'b00;
    ALUSrcB       = 2'b00;
    alu_op        = 2'b00;
    pc_update     = 1'b0;
    branch        = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    case (state)
      FETCH: begin
        ir_write_raw = 1'b1;
        ALUSrcB      = 2'b10;
        ResultSrc    = 2'b10;
        pc_update    = 1'b1;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      MEMREAD: AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc     = 2'b01;
        reg_write_raw = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc        = 1'b1;
        mem_write_raw = 1'b1;
      end
      EXECUTER: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b10;
      end
      EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = 2'b10;
      end
      ALUWB: reg_write_raw = 1'b1;
      BEQ: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b01;
        branch  = 1'b1;
      end
      JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
      end
      default: ;
    endcase
  end

  // Architectural write enables are gated by reset so no write escapes while
  // the state register is being forced back to FETCH.
  assign PCWrite  = ~reset & (pc_update | (branch & Zero));
  assign IRWrite  = ~reset & ir_write_raw;
  assign RegWrite = ~reset & reg_write_raw;
  assign MemWrite = ~reset & mem_write_raw;

  always_comb begin
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  always_comb begin
    ALUControl = 3'b000;
    case (alu_op)
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  ALUControl = ({op[5], funct7b5} == 2'b11) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

endmodule

// File: doc/main_fsm.md
MAIN_FSM -- requirements
Module: main_fsm

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed for RV32I.
REQ-002 The block SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for the state register.
REQ-004 reset  input  1  synchronous, active-high reset; forces the state to FETCH.
REQ-005 op  input  7  opcode field instr[6:0] from the instruction register.
REQ-006 funct3  input  3  instr[14:12].
REQ-007 funct7b5  input  1  instr[30].
REQ-008 Zero  input  1  ALU zero flag (ALUResult == 0).
REQ-009 PCWrite  output  1  PC register enable.
REQ-010 AdrSrc  output  1  memory address select: 0 = PC, 1 = result.
REQ-011 MemWrite  output  1  data memory write enable.
REQ-012 IRWrite  output  1  instruction register and OldPC enable.
REQ-013 RegWrite  output  1  register file write enable.
REQ-014 ResultSrc  output  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
REQ-015 ALUSrcA  output  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1.
REQ-016 ALUSrcB  output  2  ALU B select: 00 = rs2, 01 = ImmExt, 10 = constant 4.
REQ-017 ImmSrc  output  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
REQ-018 ALUControl  output  3  ALU operation: 000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt.
REQ-019 state  output  4  current state encoding, for debug only.

Function
REQ-020 States and encodings SHALL be:
- FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5
- EXECUTER 6, EXECUTEI 7, ALUWB 8, BEQ 9, JAL 10
- codes 11 to 15 are illegal.
REQ-021 Transitions SHALL occur once per rising clk edge when reset is 0:
- FETCH -> DECODE.
- DECODE -> by op: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI; 1100011 -> BEQ; 1101111 -> JAL; any other op -> FETCH.
- MEMADR -> MEMREAD if op = 0000011, else MEMWRITE.
- MEMREAD -> MEMWB.
- MEMWB, MEMWRITE, BEQ -> FETCH.
- EXECUTER, EXECUTEI, JAL -> ALUWB.
- ALUWB -> FETCH.
- Any illegal code -> FETCH.
REQ-022 Per-state outputs SHALL be as follows; any output not listed is 0. ALUOp is internal.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
- MEMREAD: ResultSrc=00, AdrSrc=1.
- MEMWB: ResultSrc=01, RegWrite=1.
- MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
- ALUWB: ResultSrc=00, RegWrite=1.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1.
REQ-023 PCWrite SHALL equal PCUpdate OR (Branch AND Zero), combinationally, within the same cycle; it is the only output that depends on Zero.
REQ-024 ImmSrc SHALL be a combinational function of op alone, independent of state:
- 0100011 -> 01; 1100011 -> 10; 1101111 -> 11; all others -> 00.
REQ-025 ALUControl SHALL be decoded combinationally:
- ALUOp=00 -> 000; ALUOp=01 -> 001.
- ALUOp=10, funct3=000 -> 001 if {op[5],funct7b5}=11, else 000.
- ALUOp=10, funct3=010 -> 101; funct3=110 -> 011; funct3=111 -> 010; any other funct3 -> 000.
REQ-026 Instruction latency SHALL be: lw 5 cycles, sw 4, R-type 4, I-type 4, jal 4, beq 3, unsupported op 2.

Reset
REQ-027 While reset = 1, PCWrite, IRWrite, RegWrite and MemWrite SHALL be forced to 0 regardless of state.
REQ-028 A rising clk edge with reset = 1 SHALL load state = FETCH (0), including when reset arrives mid-instruction; no partial write is issued afterwards.
REQ-029 On the first cycle after reset deasserts, the outputs SHALL be the FETCH values, with PCWrite = 1 and IRWrite = 1.

Verification
REQ-030 Reset, then op=0000011 held -> state sequence 0,1,2,3,4,0; RegWrite=1 only in state 4 with ResultSrc=01; AdrSrc=1 in state 3.
REQ-031 op=0100011 -> state sequence 0,1,2,5,0; MemWrite=1 for exactly one cycle; ImmSrc=01 throughout.
REQ-032 op=0110011, funct3=000, funct7b5=1 -> ALUControl=001 in EXECUTER; with funct7b5=0 -> 000; with funct3=010 -> 101.
REQ-033 op=1100011 -> in BEQ, Zero=1 gives PCWrite=1 and Zero=0 gives PCWrite=0; ALUControl=001; next state is FETCH.
REQ-034 op=1101111 -> state sequence 0,1,10,8,0; PCWrite=1 in JAL; RegWrite=1 in ALUWB.
REQ-035 op=0000011 with reset asserted while in MEMREAD -> state=0 at the next edge, no RegWrite pulse; op=1111111 -> state sequence 0,1,0.
